// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit on an as_/rw/rdy_ bus, with read-modify-write for sub-word stores
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int BA_W   = ADDR_W + OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_en,
    input  logic [3:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [BA_W-1:0]   ex_out,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rdy_,
    output logic [ADDR_W-1:0] addr,
    output logic              as_,
    output logic              rw,
    output logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              miss_align,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, ACC, RMW_RD, RMW_WR} state_t;

    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
    localparam logic [15:0]       WAIT_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [15:0]       wait_cnt;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        sz_q;
    logic              ld_q, sgn_q;
    logic [DATA_W-1:0] st_data_q;

    logic              dec_ld, dec_st, dec_sgn, dec_sub, dec_aligned;
    logic [1:0]        dec_sz;
    logic [OFF_W-1:0]  dec_off;
    logic              accept, timeout_hit;

    logic [6:0]        lane_bits;
    logic [OFF_W+2:0]  bit_off;
    logic [DATA_W-1:0] lane_mask, lane_msb, rd_shift, ld_val, st_mask, merged;

    assign dec_off = ex_out[OFF_W-1:0];

    // dec_sz: 0 byte, 1 half, 2 word, 3 double; 64-bit-only ops decode as NOP on a 32-bit bus
    always_comb begin
        dec_ld  = 1'b0;
        dec_st  = 1'b0;
        dec_sgn = 1'b0;
        dec_sz  = 2'd0;
        case (ex_mem_op)
            4'd1:  begin dec_ld = 1'b1; dec_sz = 2'd0; dec_sgn = 1'b1; end
            4'd2:  begin dec_ld = 1'b1; dec_sz = 2'd1; dec_sgn = 1'b1; end
            4'd3:  begin dec_ld = 1'b1; dec_sz = 2'd2; dec_sgn = 1'b1; end
            4'd4:  begin dec_ld = (DATA_W == 64); dec_sz = 2'd3; end
            4'd5:  begin dec_ld = 1'b1; dec_sz = 2'd0; end
            4'd6:  begin dec_ld = 1'b1; dec_sz = 2'd1; end
            4'd7:  begin dec_ld = (DATA_W == 64); dec_sz = 2'd2; end
            4'd8:  begin dec_st = 1'b1; dec_sz = 2'd0; end
            4'd9:  begin dec_st = 1'b1; dec_sz = 2'd1; end
            4'd10: begin dec_st = 1'b1; dec_sz = 2'd2; end
            4'd11: begin dec_st = (DATA_W == 64); dec_sz = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        case (dec_sz)
            2'd0:    dec_aligned = 1'b1;
            2'd1:    dec_aligned = ~dec_off[0];
            2'd2:    dec_aligned = (dec_off[1:0] == 2'b00);
            default: dec_aligned = (dec_off == '0);
        endcase
    end

    assign dec_sub = (DATA_W == 32) ? (dec_sz != 2'd2) : (dec_sz != 2'd3);

    // A full-width lane makes the shifted one fall off the top, so the mask becomes all ones
    always_comb begin
        lane_bits = 7'd8 << sz_q;
        lane_mask = (ONE << lane_bits) - ONE;
        lane_msb  = lane_mask & ~(lane_mask >> 1);
        bit_off   = {off_q, 3'b000};
        rd_shift  = rd_data >> bit_off;
        ld_val    = rd_shift & lane_mask;
        if (sgn_q && |(rd_shift & lane_msb)) begin
            ld_val = ld_val | ~lane_mask;
        end
        st_mask = lane_mask << bit_off;
        merged  = (rd_data & ~st_mask) | ((st_data_q << bit_off) & st_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        out         = '0;
        out_valid   = 1'b0;
        miss_align  = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (ex_en) begin
                        if (!dec_ld && !dec_st) begin
                            out       = DATA_W'(ex_out);
                            out_valid = 1'b1;
                        end else if (!dec_aligned) begin
                            miss_align = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            accept    = 1'b1;
                            state_nxt = (dec_st && dec_sub) ? RMW_RD : ACC;
                        end
                    end
                end
                default: begin
                    if (!rdy_) begin
                        if (state == RMW_RD) begin
                            stall     = 1'b1;
                            state_nxt = RMW_WR;
                        end else begin
                            out_valid = 1'b1;
                            out       = (state == ACC && ld_q) ? ld_val : '0;
                            state_nxt = IDLE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_hit = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            as_       <= 1'b1;
            rw        <= 1'b1;
            addr      <= '0;
            wr_data   <= '0;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            off_q     <= '0;
            sz_q      <= '0;
            ld_q      <= 1'b0;
            sgn_q     <= 1'b0;
            st_data_q <= '0;
        end else begin
            bus_err <= timeout_hit;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (state != IDLE && rdy_) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (accept) begin
                addr      <= ex_out[BA_W-1:OFF_W];
                off_q     <= dec_off;
                sz_q      <= dec_sz;
                ld_q      <= dec_ld;
                sgn_q     <= dec_sgn;
                st_data_q <= ex_mem_wr_data;
                as_       <= 1'b0;
                rw        <= ~(dec_st && !dec_sub);
                if (dec_st && !dec_sub) begin
                    wr_data <= ex_mem_wr_data;
                end
            end else if (state == RMW_RD && !rdy_) begin
                // as_ stays low: the write phase follows the read back-to-back
                wr_data <= merged;
                rw      <= 1'b0;
            end else if (state != IDLE && state_nxt == IDLE) begin
                as_ <= 1'b1;
                rw  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit at 32-bit and 64-bit data widths
module tb_mem_access_unit;
    localparam int T32 = 4;
    localparam int T64 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ex_en, sel64, rdy_n, en32, en64;
    logic [3:0]  op;
    logic [63:0] wdata, rdata;
    logic [32:0] ea;

    logic [29:0] addr32, addr64;
    logic        as32, rw32, stall32, ov32, ma32, be32;
    logic        as64, rw64, stall64, ov64, ma64, be64;
    logic [31:0] wd32, out32;
    logic [63:0] wd64, out64;

    assign en32 = ex_en & ~sel64;
    assign en64 = ex_en & sel64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(30), .TIMEOUT(T32)) u32 (
        .clk(clk), .reset(reset), .ex_en(en32), .ex_mem_op(op), .ex_mem_wr_data(wdata[31:0]),
        .ex_out(ea[31:0]), .rd_data(rdata[31:0]), .rdy_(rdy_n), .addr(addr32), .as_(as32),
        .rw(rw32), .wr_data(wd32), .stall(stall32), .out(out32), .out_valid(ov32),
        .miss_align(ma32), .bus_err(be32));

    mem_access_unit #(.DATA_W(64), .ADDR_W(30), .TIMEOUT(T64)) u64 (
        .clk(clk), .reset(reset), .ex_en(en64), .ex_mem_op(op), .ex_mem_wr_data(wdata),
        .ex_out(ea), .rd_data(rdata), .rdy_(rdy_n), .addr(addr64), .as_(as64),
        .rw(rw64), .wr_data(wd64), .stall(stall64), .out(out64), .out_valid(ov64),
        .miss_align(ma64), .bus_err(be64));

    logic [29:0] cur_addr;
    logic        cur_as, cur_rw, cur_stall, cur_ov, cur_ma, cur_be;
    logic [63:0] cur_wd, cur_out;

    always_comb begin
        cur_addr  = sel64 ? addr64 : addr32;
        cur_as    = sel64 ? as64 : as32;
        cur_rw    = sel64 ? rw64 : rw32;
        cur_stall = sel64 ? stall64 : stall32;
        cur_ov    = sel64 ? ov64 : ov32;
        cur_ma    = sel64 ? ma64 : ma32;
        cur_be    = sel64 ? be64 : be32;
        cur_wd    = sel64 ? wd64 : {32'd0, wd32};
        cur_out   = sel64 ? out64 : {32'd0, out32};
    end

    int checks = 0;
    int failures = 0;

    logic        exp_on = 1'b0;
    logic        exp_stall, exp_ov, exp_ma, exp_as, exp_rw, exp_be;
    logic        chk_out, chk_bus, chk_wd;
    logic [29:0] exp_addr;
    logic [63:0] exp_out, exp_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            check("stall", 64'(cur_stall), 64'(exp_stall));
            check("out_valid", 64'(cur_ov), 64'(exp_ov));
            check("miss_align", 64'(cur_ma), 64'(exp_ma));
            check("as_", 64'(cur_as), 64'(exp_as));
            check("bus_err", 64'(cur_be), 64'(exp_be));
            if (chk_out) check("out", cur_out, exp_out);
            if (chk_bus) begin
                check("rw", 64'(cur_rw), 64'(exp_rw));
                check("addr", 64'(cur_addr), 64'(exp_addr));
            end
            if (chk_wd) check("wr_data", cur_wd, exp_wd);
        end
    end

    function automatic int nbytes(input logic [3:0] o, input int w);
        int n;
        case (o)
            4'd1, 4'd5, 4'd8: n = 1;
            4'd2, 4'd6, 4'd9: n = 2;
            4'd3, 4'd10:      n = 4;
            4'd7:             n = (w == 64) ? 4 : 0;
            4'd4, 4'd11:      n = (w == 64) ? 8 : 0;
            default:          n = 0;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] ref_load(input logic [3:0] o, input logic [32:0] a,
                                             input logic [63:0] rd, input int w);
        int n, off;
        logic [63:0] v, m;
        n   = nbytes(o, w);
        off = int'(a[5:0]) % (w / 8);
        v   = rd >> (8 * off);
        m   = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v   = v & m;
        if (o >= 4'd1 && o <= 4'd4 && n >= 1 && n < 8 && v[8*n-1]) v = v | ~m;
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] ref_merge(input logic [3:0] o, input logic [32:0] a,
                                              input logic [63:0] wd, input logic [63:0] rd, input int w);
        int n, off;
        logic [63:0] r;
        n   = nbytes(o, w);
        off = int'(a[5:0]) % (w / 8);
        r   = rd;
        for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        if (w == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_stall = 1'b0; exp_ov = 1'b0; exp_ma = 1'b0; exp_as = 1'b1; exp_be = 1'b0;
        exp_out = 64'd0; chk_out = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    endtask

    task automatic bus_phase(input int nw, input logic [63:0] rd, input int tmo, input logic rwv,
                             input logic [63:0] wdv, input bit final_ph, input logic [63:0] outv,
                             output bit to);
        to = 1'b0;
        exp_as = 1'b0; exp_rw = rwv; chk_bus = 1'b1; chk_wd = !rwv; exp_wd = wdv;
        exp_ov = 1'b0; exp_ma = 1'b0; exp_be = 1'b0; chk_out = 1'b0;
        for (int k = 1; k <= nw; k++) begin
            rdy_n = 1'b1; rdata = {$urandom, $urandom};
            exp_stall = (k < tmo);
            tick();
            if (k == tmo) begin
                to = 1'b1;
                return;
            end
        end
        rdy_n = 1'b0; rdata = rd;
        exp_stall = !final_ph; exp_ov = final_ph; exp_out = outv; chk_out = final_ph;
        tick();
        rdy_n = 1'b1;
    endtask

    task automatic txn(input bit s64, input logic [3:0] o, input logic [32:0] a, input logic [63:0] wd,
                       input int nw1, input logic [63:0] rd1, input int nw2, input logic [63:0] rd2);
        int w, tmo, n;
        bit ld, sub, to, mem_ok;
        logic [63:0] wdw;
        w   = s64 ? 64 : 32;
        tmo = s64 ? T64 : T32;
        n   = nbytes(o, w);
        ld  = (n > 0) && (o <= 4'd7);
        sub = (n > 0) && (o >= 4'd8) && (n * 8 < w);
        mem_ok = (n > 0) && (int'(a[5:0]) % n == 0);
        wdw = (w == 32) ? (wd & 64'hFFFF_FFFF) : wd;
        sel64 = s64; ex_en = 1'b1; op = o; ea = a; wdata = wd; rdy_n = 1'b1;
        rdata = {$urandom, $urandom};
        exp_idle();
        exp_addr = s64 ? a[32:3] : a[31:2];
        if (n == 0) begin
            exp_ov = 1'b1; exp_out = s64 ? 64'(a) : 64'(a[31:0]);
        end else if (!mem_ok) begin
            exp_ma = 1'b1;
        end else begin
            exp_stall = 1'b1; chk_out = 1'b0;
        end
        tick();
        to = 1'b0;
        if (mem_ok) begin
            bus_phase(nw1, rd1, tmo, ld || sub, wdw, !sub, ld ? ref_load(o, a, rd1, w) : 64'd0, to);
            if (!to && sub)
                bus_phase(nw2, rd2, tmo, 1'b0, ref_merge(o, a, wd, rd1, w), 1'b1, 64'd0, to);
        end
        ex_en = 1'b0; rdy_n = 1'b1;
        exp_idle(); exp_be = to;
        tick();
        if (to) begin
            exp_be = 1'b0;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_en = 1'b0; sel64 = 1'b0; op = 4'd0; ea = '0;
        wdata = '0; rdata = '0; rdy_n = 1'b1;
        exp_idle(); exp_rw = 1'b1; exp_addr = '0; exp_wd = '0;

        check("pin_lh", ref_load(4'd2, 33'h102, 64'h8001_1234, 32), 64'hFFFF_8001);
        check("pin_sb", ref_merge(4'd8, 33'h101, 64'hAB, 64'h1122_3344, 32), 64'h1122_AB44);
        check("pin_lwu", ref_load(4'd7, 33'h104, 64'hDEAD_BEEF_0000_0001, 64), 64'hDEAD_BEEF);
        check("pin_lw64", ref_load(4'd3, 33'h104, 64'h8000_0000_1234_5678, 64), 64'hFFFF_FFFF_8000_0000);

        tick();
        ex_en = 1'b1; op = 4'd3; ea = 33'h100;
        exp_idle(); chk_bus = 1'b1; exp_rw = 1'b1; exp_addr = '0; chk_wd = 1'b1; exp_wd = '0;
        exp_on = 1'b1;
        tick();
        sel64 = 1'b1;
        tick();
        reset = 1'b0; ex_en = 1'b0; sel64 = 1'b0;
        exp_idle();
        tick();

        txn(0, 4'd2,  33'h102,       64'h0,         0, 64'h8001_1234, 0, 64'h0);
        txn(0, 4'd8,  33'h101,       64'hAB,        0, 64'h1122_3344, 0, 64'h0);
        txn(0, 4'd3,  33'h102,       64'h0,         0, 64'h0,         0, 64'h0);
        txn(0, 4'd9,  33'h101,       64'h0,         0, 64'h0,         0, 64'h0);
        txn(0, 4'd0,  33'h1234_5678, 64'h0,         0, 64'h0,         0, 64'h0);
        txn(0, 4'd13, 33'hFFFF_FFFF, 64'h0,         0, 64'h0,         0, 64'h0);
        txn(0, 4'd4,  33'h77,        64'h0,         0, 64'h0,         0, 64'h0);
        txn(0, 4'd3,  33'h200,       64'h0,        10, 64'h0,         0, 64'h0);
        txn(0, 4'd1,  33'h103,       64'h0,         1, 64'h7F00_0000, 0, 64'h0);
        txn(0, 4'd5,  33'h103,       64'h0,         2, 64'h8000_0000, 0, 64'h0);
        txn(0, 4'd6,  33'h102,       64'h0,         0, 64'h8765_0000, 0, 64'h0);
        txn(0, 4'd3,  33'h300,       64'h0,         3, 64'hF00D_1234, 0, 64'h0);
        txn(0, 4'd10, 33'h204,       64'hCAFE_BABE, 2, 64'h0,         0, 64'h0);
        txn(0, 4'd9,  33'h102,       64'h5A5A,      1, 64'hAABB_CCDD, 2, 64'h0);
        txn(0, 4'd9,  33'h100,       64'hBEEF,      0, 64'h1111_2222, 5, 64'h0);

        txn(1, 4'd7,  33'h104, 64'h0,                   0, 64'hDEAD_BEEF_0000_0001, 0, 64'h0);
        txn(1, 4'd0,  33'h55,  64'h0,                   0, 64'h0,                   0, 64'h0);
        txn(1, 4'd3,  33'h104, 64'h0,                   1, 64'h8000_0000_1234_5678, 0, 64'h0);
        txn(1, 4'd4,  33'h108, 64'h0,                   2, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
        txn(1, 4'd10, 33'h104, 64'h1357_9BDF,           0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
        txn(1, 4'd11, 33'h110, 64'hA5A5_5A5A_0F0F_F0F0, 1, 64'h0,                   0, 64'h0);
        txn(1, 4'd4,  33'h104, 64'h0,                   0, 64'h0,                   0, 64'h0);
        txn(1, 4'd2,  33'h106, 64'h0,                   0, 64'h9ABC_0000_0000_0000, 0, 64'h0);
        txn(1, 4'd3,  33'h200, 64'h0,                   8, 64'h0,                   0, 64'h0);

        sel64 = 1'b0; ex_en = 1'b1; op = 4'd8; ea = 33'h101; wdata = 64'hCD; rdy_n = 1'b1;
        exp_idle(); exp_stall = 1'b1; chk_out = 1'b0;
        tick();
        exp_as = 1'b0; chk_bus = 1'b1; exp_rw = 1'b1; exp_addr = 30'h40;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1; exp_stall = 1'b0; chk_out = 1'b1; exp_out = 64'd0;
        tick();
        reset = 1'b0; ex_en = 1'b0;
        exp_idle(); chk_bus = 1'b1; exp_rw = 1'b1; exp_addr = '0;
        tick();
        exp_idle(); rdy_n = 1'b0; rdata = 64'hFFFF_FFFF;
        tick();
        tick();
        rdy_n = 1'b1;
        txn(0, 4'd3, 33'h108, 64'h0, 1, 64'h2468_ACE0, 0, 64'h0);

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
